// File: rtl/oclib_uart_tx_arb.sv
// Round-robin arbiter feeding one 8N1 UART transmitter; a grant is held for a whole message.
// Optional owner-idle timeout enabled by defining OCLIB_UART_TX_ARB_TIMEOUT_EN.
module oclib_uart_tx_arb #(
    parameter int unsigned ClockHz       = 100000000,
    parameter int unsigned Baud          = 115200,
    parameter int unsigned Requesters    = 4,
    parameter int unsigned TimeoutCycles = 65536
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [Requesters-1:0]           reqValid,
    input  logic [Requesters*8-1:0]         reqData,
    input  logic [Requesters-1:0]           reqLast,
    output logic [Requesters-1:0]           reqReady,
    output logic                            tx,
    output logic                            grantValid,
    output logic [$clog2(Requesters)-1:0]   grantId
);

    localparam int unsigned IdW       = $clog2(Requesters);
    localparam int unsigned BitCycles = ClockHz / Baud;
    localparam int unsigned CycW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;

    if (Requesters < 2 || Requesters > 8 || TimeoutCycles < 1) begin : g_bad_param
        $error("oclib_uart_tx_arb: Requesters must be 2..8 and TimeoutCycles >= 1");
    end

    typedef enum logic [1:0] {IDLE, LOCKED, SEND} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  grant_id_q, grant_id_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic            last_q, last_d;
    logic [9:0]      shift_q, shift_d;
    logic [3:0]      bit_q, bit_d;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [IdW-1:0]  winner;
    logic            accept;

`ifdef OCLIB_UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
`endif

    // ptr_q holds the index the next search starts from (last grant + 1)
    always_comb begin
        int unsigned idx;
        logic        found;
        winner = ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < Requesters; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= Requesters) idx = idx - Requesters;
            if (!found && reqValid[IdW'(idx)]) begin
                winner = IdW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign accept     = (state_q == LOCKED) && reqValid[grant_id_q];
    assign tx         = (state_q == SEND) ? shift_q[0] : 1'b1;
    assign grantValid = (state_q != IDLE);
    assign grantId    = grant_id_q;

    always_comb begin
        reqReady = '0;
        if (state_q == LOCKED) reqReady[grant_id_q] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        cyc_d      = cyc_q;
`ifdef OCLIB_UART_TX_ARB_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|reqValid) begin
                    grant_id_d = winner;
                    ptr_d      = (winner == IdW'(Requesters - 1)) ? '0 : winner + 1'b1;
                    state_d    = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    shift_d = {1'b1, reqData[{grant_id_q, 3'b000} +: 8], 1'b0};
                    last_d  = reqLast[grant_id_q];
                    bit_d   = '0;
                    cyc_d   = '0;
                    state_d = SEND;
                end
`ifdef OCLIB_UART_TX_ARB_TIMEOUT_EN
                else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_d == ToW'(TimeoutCycles)) state_d = IDLE;
                end
`endif
            end
            SEND: begin
                if (cyc_q == CycW'(BitCycles - 1)) begin
                    cyc_d = '0;
                    if (bit_q == 4'd9) begin
                        state_d = last_q ? IDLE : LOCKED;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b1, shift_q[9:1]};
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            ptr_q      <= '0;
            last_q     <= 1'b0;
            shift_q    <= '1;
            bit_q      <= '0;
            cyc_q      <= '0;
`ifdef OCLIB_UART_TX_ARB_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            cyc_q      <= cyc_d;
`ifdef OCLIB_UART_TX_ARB_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_oclib_uart_tx_arb.sv
// Directed bench for oclib_uart_tx_arb: 10 clocks per bit, 4 requesters.
module tb_oclib_uart_tx_arb;

    logic        clock;
    logic        reset;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqLast;
    logic [3:0]  reqReady;
    logic        tx;
    logic        grantValid;
    logic [1:0]  grantId;

    int n_checks = 0;
    int n_pass   = 0;

    oclib_uart_tx_arb #(
        .ClockHz      (1000000),
        .Baud         (100000),
        .Requesters   (4),
        .TimeoutCycles(50)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqData   (reqData),
        .reqLast   (reqLast),
        .reqReady  (reqReady),
        .tx        (tx),
        .grantValid(grantValid),
        .grantId   (grantId)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        reqValid[i]      = v;
        reqData[i*8 +: 8] = d;
        reqLast[i]       = l;
    endtask

    // Samples ncyc cycles of an 8N1 frame starting at the start bit
    task automatic expect_frame(input string tag, input logic [7:0] b, input int ncyc);
        logic [9:0] f;
        int errs_tx, errs_rdy, errs_gv;
        f = {1'b1, b, 1'b0};
        errs_tx = 0; errs_rdy = 0; errs_gv = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (tx !== f[k / 10]) errs_tx++;
            if (reqReady !== 4'b0000) errs_rdy++;
            if (grantValid !== 1'b1) errs_gv++;
            tick();
        end
        check({tag, "_tx"}, errs_tx, 0);
        check({tag, "_rdy_low"}, errs_rdy, 0);
        check({tag, "_gv_high"}, errs_gv, 0);
    endtask

    // From IDLE: one cycle to grant, one to accept, then a full frame
    task automatic grant_and_send(input string tag, input int exp_id, input logic [7:0] b);
        tick();
        check({tag, "_gv"}, grantValid, 1);
        check({tag, "_id"}, grantId, exp_id);
        check({tag, "_rdy"}, reqReady, 1 << exp_id);
        tick();
        expect_frame(tag, b, 100);
    endtask

    initial begin
        reset    = 1'b1;
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_gv", grantValid, 0);
        check("rst_id", grantId, 0);
        check("rst_rdy", reqReady, 0);
        reset = 1'b0;
        tick();
        check("idle_tx", tx, 1);

        // single last byte from requester 2
        set_req(2, 1'b1, 8'hA5, 1'b1);
        grant_and_send("t1", 2, 8'hA5);
        check("t1_gv_fall", grantValid, 0);
        check("t1_tx_idle", tx, 1);
        set_req(2, 1'b0, 8'h00, 1'b0);

        // two continuous requesters alternate (pointer starts after 2 -> 3)
        set_req(0, 1'b1, 8'h10, 1'b1);
        set_req(1, 1'b1, 8'h20, 1'b1);
        for (int g = 0; g < 4; g++) begin
            grant_and_send($sformatf("t2_g%0d", g), g % 2, (g % 2) ? 8'h20 : 8'h10);
            check($sformatf("t2_gap%0d", g), grantValid, 0);
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);

        // multi-byte message holds off requester 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1, 1'b1, 8'h11, 1'b0);
        set_req(3, 1'b1, 8'h99, 1'b1);
        grant_and_send("t3_b0", 1, 8'h11);
        check("t3_hold0_gv", grantValid, 1);
        check("t3_hold0_rdy", reqReady, 4'b0010);
        set_req(1, 1'b1, 8'h22, 1'b0);
        tick();
        expect_frame("t3_b1", 8'h22, 100);
        check("t3_hold1_rdy", reqReady, 4'b0010);
        set_req(1, 1'b1, 8'h33, 1'b1);
        tick();
        expect_frame("t3_b2", 8'h33, 100);
        check("t3_end_gv", grantValid, 0);
        check("t3_end_rdy", reqReady, 0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        grant_and_send("t3_r3", 3, 8'h99);

        // after granting 3, requester 0 wins over 3 (wrap-around)
        set_req(0, 1'b1, 8'h5A, 1'b1);
        grant_and_send("t6_wrap", 0, 8'h5A);
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b0, 8'h00, 1'b0);
        check("t6_end_gv", grantValid, 0);

        // reset 35 cycles into a byte, then a clean byte
        set_req(2, 1'b1, 8'hC3, 1'b1);
        tick();
        check("t4_id", grantId, 2);
        tick();
        expect_frame("t4_part", 8'hC3, 35);
        reset = 1'b1;
        tick();
        check("t4_rst_tx", tx, 1);
        check("t4_rst_gv", grantValid, 0);
        check("t4_rst_id", grantId, 0);
        check("t4_rst_rdy", reqReady, 0);
        reset = 1'b0;
        set_req(2, 1'b1, 8'h3C, 1'b1);
        grant_and_send("t4_new", 2, 8'h3C);
        check("t4_new_gv", grantValid, 0);
        set_req(2, 1'b0, 8'h00, 1'b0);

`ifdef OCLIB_UART_TX_ARB_TIMEOUT_EN
        // owner goes quiet mid-message; grant released after 50 idle cycles
        set_req(0, 1'b1, 8'h81, 1'b0);
        set_req(1, 1'b1, 8'h42, 1'b1);
        tick();
        check("t5_id", grantId, 0);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        expect_frame("t5_b", 8'h81, 100);
        check("t5_locked", grantValid, 1);
        repeat (49) tick();
        check("t5_pre_to", grantValid, 1);
        tick();
        check("t5_to", grantValid, 0);
        grant_and_send("t5_r1", 1, 8'h42);
        set_req(1, 1'b0, 8'h00, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
